// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and helpers for the register-file write-port control logic.
package regfile_ctrl_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int NUM_REGS      = 32;
  localparam int ZERO_REG      = 0;
  localparam int MAX_REQ       = 8;
  localparam int REG_BUS_MAX_W = REG_ADDR_W * MAX_REQ;

  // Pull destination-register slice idx out of a packed reg bus (padded to MAX_REQ entries).
  function automatic logic [REG_ADDR_W-1:0] reg_slice(input logic [REG_BUS_MAX_W-1:0] bus,
                                                      input int unsigned idx);
    return bus[idx*REG_ADDR_W +: REG_ADDR_W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter for the register-file write port.
// Build option RR_ARB_EN: round-robin with a last-grant pointer; otherwise fixed
// priority (lowest index wins) with no state.
module rr_arbiter #(
  parameter int N = 3
) (
`ifdef RR_ARB_EN
  input  logic         clock,
  input  logic         reset,
  input  logic         accept_in,
`endif
  input  logic [N-1:0] req_in,
  output logic [N-1:0] grant_out
);

`ifdef RR_ARB_EN
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;
  int               idx;

  // Search starts just past the last granted index and wraps modulo N.
  always_comb begin
    grant_out = '0;
    gnt_idx   = ptr_q;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req_in[idx]) begin
        grant_out[idx] = 1'b1;
        gnt_idx        = PTR_W'(idx);
        found          = 1'b1;
      end
    end
    ptr_d = accept_in ? gnt_idx : ptr_q;
  end

  // Pointer remembers the last accepted index; reset points at N-1 so index 0 goes first.
  always_ff @(posedge clock) begin
    if (!reset) ptr_q <= PTR_W'(N - 1);
    else        ptr_q <= ptr_d;
  end
`else
  logic found;

  // Fixed priority: lowest requesting index wins.
  always_comb begin
    grant_out = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_in[k]) begin
        grant_out[k] = 1'b1;
        found        = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter with a 32-entry busy scoreboard for decode stalls.
// Build option RR_ARB_EN selects round-robin arbitration (default: fixed priority).
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N-1:0]            req_valid_in,
  input  logic [REG_ADDR_W*N-1:0] req_reg_in,
  input  logic [W*N-1:0]          req_data_in,
  output logic [N-1:0]            req_ready_out,
  output logic                    write_en_out,
  output logic [REG_ADDR_W-1:0]   write_reg_out,
  output logic [W-1:0]            write_data_out,
  input  logic                    claim_en_in,
  input  logic [REG_ADDR_W-1:0]   claim_reg_in,
  input  logic [REG_ADDR_W-1:0]   chk_reg1_in,
  input  logic [REG_ADDR_W-1:0]   chk_reg2_in,
  output logic                    stall_out
);

  logic [N-1:0]             grant;
  logic                     accept;
  logic [REG_BUS_MAX_W-1:0] reg_bus_pad;
  logic [REG_ADDR_W-1:0]    sel_reg;
  logic [W-1:0]             sel_data;

  logic                     we_q;
  logic [REG_ADDR_W-1:0]    reg_q;
  logic [W-1:0]             data_q;
  logic [NUM_REGS-1:0]      busy_q;
  logic [NUM_REGS-1:0]      busy_d;

  rr_arbiter #(.N(N)) u_arb (
`ifdef RR_ARB_EN
    .clock     (clock),
    .reset     (reset),
    .accept_in (accept),
`endif
    .req_in    (req_valid_in),
    .grant_out (grant)
  );

  // Grants are suppressed while reset is held so nothing is accepted during reset.
  assign req_ready_out = reset ? grant : '0;
  assign accept        = |req_ready_out;
  assign reg_bus_pad   = REG_BUS_MAX_W'(req_reg_in);

  // Mux the granted requester's destination and data.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (req_ready_out[i]) begin
        sel_reg  = reg_slice(reg_bus_pad, i);
        sel_data = req_data_in[i*W +: W];
      end
    end
  end

  // Write-port register: one cycle from accept to the register-file write; r0 writes are swallowed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      we_q   <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      we_q <= accept && (sel_reg != REG_ADDR_W'(ZERO_REG));
      if (accept) begin
        reg_q  <= sel_reg;
        data_q <= sel_data;
      end
    end
  end

  // Scoreboard next state: writeback clears, claim sets afterwards so claim wins; r0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (we_q)        busy_d[reg_q]        = 1'b0;
    if (claim_en_in) busy_d[claim_reg_in] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clock) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign write_en_out   = we_q;
  assign write_reg_out  = reg_q;
  assign write_data_out = data_q;
  assign stall_out      = busy_q[chk_reg1_in] | busy_q[chk_reg2_in];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (W=32, N=3), both arbitration builds.
module tb_regfile_write_arbiter;

  localparam int W = 32;
  localparam int N = 3;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req_valid_in;
  logic [5*N-1:0] req_reg_in;
  logic [W*N-1:0] req_data_in;
  logic [N-1:0]   req_ready_out;
  logic           write_en_out;
  logic [4:0]     write_reg_out;
  logic [W-1:0]   write_data_out;
  logic           claim_en_in;
  logic [4:0]     claim_reg_in;
  logic [4:0]     chk_reg1_in;
  logic [4:0]     chk_reg2_in;
  logic           stall_out;

  int n_tests;
  int n_fail;

  logic [N-1:0] exp_g   [6];
  logic [4:0]   exp_reg [6];

  regfile_write_arbiter #(.W(W), .N(N)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid_in   (req_valid_in),
    .req_reg_in     (req_reg_in),
    .req_data_in    (req_data_in),
    .req_ready_out  (req_ready_out),
    .write_en_out   (write_en_out),
    .write_reg_out  (write_reg_out),
    .write_data_out (write_data_out),
    .claim_en_in    (claim_en_in),
    .claim_reg_in   (claim_reg_in),
    .chk_reg1_in    (chk_reg1_in),
    .chk_reg2_in    (chk_reg2_in),
    .stall_out      (stall_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset        = 1'b0;
    req_valid_in = '0;
    req_reg_in   = '0;
    req_data_in  = '0;
    claim_en_in  = 1'b0;
    claim_reg_in = '0;
    chk_reg1_in  = 5'd7;
    chk_reg2_in  = 5'd9;

    // Reset state
    tick();
    tick();
    req_valid_in = 3'b111;
    #1;
    check_eq("rst_ready", req_ready_out, 3'b000);
    check_eq("rst_we", write_en_out, 1'b0);
    check_eq("rst_reg", write_reg_out, 5'd0);
    check_eq("rst_data", write_data_out, 32'h0);
    check_eq("rst_stall", stall_out, 1'b0);
    req_valid_in = '0;
    reset = 1'b1;
    tick();
    check_eq("idle_ready", req_ready_out, 3'b000);

    // Single request from requester 1
    req_valid_in = 3'b010;
    req_reg_in[5 +: 5]  = 5'd5;
    req_data_in[W +: W] = 32'hDEADBEEF;
    #1;
    check_eq("single_ready", req_ready_out, 3'b010);
    tick();
    req_valid_in = '0;
    check_eq("single_we", write_en_out, 1'b1);
    check_eq("single_reg", write_reg_out, 5'd5);
    check_eq("single_data", write_data_out, 32'hDEADBEEF);

    // Reset pulse so the pointer starts from N-1 again
    reset = 1'b0;
    tick();
    check_eq("rst2_we", write_en_out, 1'b0);
    reset = 1'b1;

    // All three requesters valid for 6 cycles
`ifdef RR_ARB_EN
    exp_g   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_reg = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
`else
    exp_g   = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    exp_reg = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
`endif
    req_reg_in  = {5'd3, 5'd2, 5'd1};
    req_data_in = {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
    req_valid_in = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq($sformatf("all_grant%0d", c), req_ready_out, exp_g[c]);
      tick();
      check_eq($sformatf("all_wreg%0d", c), write_reg_out, exp_reg[c]);
    end
    req_valid_in = '0;
    tick();

    // Write to register 0 from requester 0
    req_valid_in = 3'b001;
    req_reg_in[0 +: 5]  = 5'd0;
    req_data_in[0 +: W] = 32'h1234;
    chk_reg1_in = 5'd0;
    chk_reg2_in = 5'd0;
    #1;
    check_eq("r0_ready", req_ready_out, 3'b001);
    tick();
    req_valid_in = '0;
    check_eq("r0_we", write_en_out, 1'b0);
    check_eq("r0_stall", stall_out, 1'b0);

    // Claim of register 0 is ignored
    claim_en_in  = 1'b1;
    claim_reg_in = 5'd0;
    tick();
    claim_en_in = 1'b0;
    check_eq("claim_r0_stall", stall_out, 1'b0);

    // Claim reg 7 then check it
    claim_en_in  = 1'b1;
    claim_reg_in = 5'd7;
    tick();
    claim_en_in = 1'b0;
    chk_reg1_in = 5'd7;
    #1;
    check_eq("claim7_stall", stall_out, 1'b1);

    // Requester 2 writes reg 7
    req_valid_in = 3'b100;
    req_reg_in[10 +: 5]     = 5'd7;
    req_data_in[2*W +: W]   = 32'h0000_A5A5;
    #1;
    check_eq("wr7_ready", req_ready_out, 3'b100);
    tick();
    req_valid_in = '0;
    check_eq("wr7_we", write_en_out, 1'b1);
    check_eq("wr7_data", write_data_out, 32'h0000_A5A5);
    check_eq("wr7_stall_pre", stall_out, 1'b1);
    tick();
    check_eq("wr7_stall_post", stall_out, 1'b0);
    check_eq("wr7_we_off", write_en_out, 1'b0);

    // Claim and clear of reg 7 on the same edge
    claim_en_in  = 1'b1;
    claim_reg_in = 5'd7;
    tick();
    claim_en_in  = 1'b0;
    req_valid_in = 3'b100;
    tick();
    req_valid_in = '0;
    check_eq("same_we", write_en_out, 1'b1);
    claim_en_in  = 1'b1;
    claim_reg_in = 5'd7;
    tick();
    claim_en_in = 1'b0;
    check_eq("same_stall", stall_out, 1'b1);

    // Reset right after accepting a write to reg 9 with busy[9] set
    claim_en_in  = 1'b1;
    claim_reg_in = 5'd9;
    tick();
    claim_en_in  = 1'b0;
    req_valid_in = 3'b001;
    req_reg_in[0 +: 5]  = 5'd9;
    req_data_in[0 +: W] = 32'h99;
    #1;
    check_eq("r9_ready", req_ready_out, 3'b001);
    tick();
    req_valid_in = '0;
    check_eq("r9_we_pending", write_en_out, 1'b1);
    reset = 1'b0;
    chk_reg1_in = 5'd9;
    chk_reg2_in = 5'd7;
    tick();
    check_eq("midrst_we", write_en_out, 1'b0);
    check_eq("midrst_reg", write_reg_out, 5'd0);
    check_eq("midrst_stall", stall_out, 1'b0);
    reset = 1'b1;
    tick();

    // Second source operand port
    claim_en_in  = 1'b1;
    claim_reg_in = 5'd12;
    tick();
    claim_en_in = 1'b0;
    chk_reg1_in = 5'd0;
    chk_reg2_in = 5'd12;
    #1;
    check_eq("chk2_stall", stall_out, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port among N result producers: ALU writeback, load writeback and the multi-cycle multiply/divide unit. It grants one requester per cycle and registers the chosen write into the register file's write-port signals. It also keeps a 32-entry busy scoreboard, so decode can stall on operands whose producer has not yet written back.

## Interface
Parameters:
- W, 32, data width
- N, 3, number of write requesters (2..8)

Ports:
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-low
- req_valid_in  in  N  requester i has a write pending
- req_reg_in  in  5*N  destination register, slice [5i+4:5i]
- req_data_in  in  W*N  write data, slice [Wi+W-1:Wi]
- req_ready_out  out  N  one-hot grant; transfer when valid & ready
- write_en_out  out  1  to register file write_en_in
- write_reg_out  out  5  to register file write_reg_in
- write_data_out  out  W  to register file write_data_in
- claim_en_in  in  1  decode reserves a destination register
- claim_reg_in  in  5  register being reserved
- chk_reg1_in  in  5  decode source operand 1
- chk_reg2_in  in  5  decode source operand 2
- stall_out  out  1  a checked source register is busy

## Operation
- Arbitration is combinational. req_ready_out has at most one bit set, and only for a requester with valid asserted. It is all zero when no request is valid.
- Accepted transfer: the granted requester's reg and data are captured into the output register.
  - write_en_out = 1 next cycle when the reg is non-zero.
  - A write to register 0 is accepted (handshake completes) but write_en_out stays 0.
- Requesters hold valid, reg and data stable until accepted.
- Scoreboard busy[31:0]:
  - claim_en_in sets busy[claim_reg_in].
  - A cycle where write_en_out = 1 clears busy[write_reg_out] at that edge, coinciding with the register file write.
- busy[0] is never set; a claim of register 0 is ignored.
- Same register claimed and cleared on the same edge: claim wins, busy stays 1.
- Claim of an already-busy register: busy stays 1. No counting.
- stall_out = busy[chk_reg1_in] | busy[chk_reg2_in], combinational.

## Timing
- Reset (reset = 0 at posedge):
  - write_en_out, write_reg_out and write_data_out go to 0.
  - busy goes to all 0.
  - The round-robin pointer goes to N-1, so requester 0 has top priority.
  - req_ready_out is forced to 0 while reset is low.
- Reset mid-operation: a captured but unwritten write is dropped; write_en_out is 0 after the edge.
- Latency, accept edge to register-file write edge: 1 cycle. Throughput is one write per cycle.
- After the clearing edge, stall_out falls in the same cycle for that register. The register file's asynchronous read already returns the new data.
- Simultaneous valid from all N requesters: one grant per cycle. Each requester is served within N cycles in round-robin mode.

## Configuration
- RR_ARB_EN defined: round-robin arbitration.
  - The pointer records the last granted index.
  - Search starts at pointer+1 modulo N.
  - The pointer updates only on an accepted transfer.
- RR_ARB_EN undefined: fixed priority, lowest index wins, no pointer state. Starvation of higher indices is permitted.

## Structure
- Package regfile_ctrl_pkg:
  - REG_ADDR_W = 5
  - NUM_REGS = 32
  - ZERO_REG = 0
  - helper function to extract the 5-bit slice i from the packed reg bus
- Sub-module rr_arbiter (parameter N): request vector in, one-hot grant out, internal pointer. Its pointer logic is compiled out without RR_ARB_EN.
- Top level holds the output register, scoreboard and stall logic.

## Test plan
- Reset, then a single request from requester 1:
  - req_valid_in=3'b010, reg 5, data 0xDEADBEEF.
  - Same cycle: ready=3'b010.
  - Next cycle: write_en_out=1, write_reg_out=5, write_data_out=0xDEADBEEF.
- All three valid for 6 cycles, RR_ARB_EN defined:
  - Grants 001, 010, 100, 001, 010, 100.
  - Without the macro: 001 every cycle.
- Write to register 0 from requester 0 with data 0x1234: ready asserted, write_en_out stays 0, busy unchanged.
- Scoreboard:
  - Claim reg 7, then chk_reg1_in=7: stall_out=1.
  - Requester 2 writes reg 7: stall_out=0 in the cycle after write_en_out=1.
  - Claim and clear of reg 7 on the same edge: stall_out remains 1.
- Reset asserted the cycle after accepting a write to reg 9 with busy[9]=1: write_en_out=0, busy all 0, stall_out=0.
